// File: rtl/fb_arbiter_pkg.sv
// Framebuffer geometry, timing constants, shared types and the cell address helper.
package fb_pkg;
  localparam int PIX_W = 15;

  typedef logic [PIX_W-1:0] pix_t;
  typedef logic [13:0]      cell_addr_t;
  typedef logic [7:0]       cell_x_t;
  typedef logic [6:0]       cell_y_t;

  localparam cell_x_t     H_CELLS   = 8'd160;
  localparam cell_y_t     V_CELLS   = 7'd100;
  localparam cell_addr_t  LAST_CELL = 14'd15999;
  localparam logic [11:0] H_ACTIVE  = 12'd1280;
  localparam logic [11:0] H_TOTAL   = 12'd1680;
  localparam logic [10:0] V_ACTIVE  = 11'd800;
  localparam logic [10:0] V_TOTAL   = 11'd828;

  typedef enum logic [1:0] {TAG_NONE, TAG_SCAN, TAG_RD} rd_tag_e;

  // y*160 built from two shifts so no multiplier is inferred.
  function automatic cell_addr_t cell_addr(input cell_x_t x, input cell_y_t y);
    return {y, 7'd0} + {2'b00, y, 5'd0} + {6'd0, x};
  endfunction
endpackage

// File: rtl/fb_arbiter_if.sv
// Host-side cell write and screen-clear signals; FB_READBACK_EN adds the cell readback port.
interface fb_arbiter_if;
  import fb_pkg::*;

  logic    wr_valid;
  logic    wr_ready;
  cell_x_t wr_x;
  cell_y_t wr_y;
  pix_t    wr_data;
  logic    clr_start;
  pix_t    clr_data;
  logic    clr_busy;
`ifdef FB_READBACK_EN
  logic    rd_valid;
  logic    rd_ready;
  cell_x_t rd_x;
  cell_y_t rd_y;
  pix_t    rd_data;
  logic    rd_data_valid;
`endif

  modport master (
    output wr_valid, wr_x, wr_y, wr_data, clr_start, clr_data,
    input  wr_ready, clr_busy
`ifdef FB_READBACK_EN
    , output rd_valid, rd_x, rd_y,
    input  rd_ready, rd_data, rd_data_valid
`endif
  );

  modport slave (
    input  wr_valid, wr_x, wr_y, wr_data, clr_start, clr_data,
    output wr_ready, clr_busy
`ifdef FB_READBACK_EN
    , input rd_valid, rd_x, rd_y,
    output rd_ready, rd_data, rd_data_valid
`endif
  );
endinterface

// File: rtl/fb_arbiter_clear_seq.sv
// Screen-clear sequencer: IDLE/FILL FSM walking cells 0..15999, one write per granted cycle.
module fb_clear_seq
  import fb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  pix_t       data_i,
  input  logic       grant_i,
  output logic       req_o,
  output cell_addr_t addr_o,
  output pix_t       data_o
);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_FILL = 1'b1;

  logic [0:0] state_q, state_d;
  cell_addr_t addr_q, addr_d;
  pix_t       data_q, data_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_FILL;
          addr_d  = '0;
          data_d  = data_i;
        end
      end
      default: begin
        if (grant_i) begin
          if (addr_q == LAST_CELL) state_d = ST_IDLE;
          else                     addr_d  = addr_q + 14'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign req_o  = (state_q == ST_FILL);
  assign addr_o = addr_q;
  assign data_o = data_q;
endmodule

// File: rtl/fb_arbiter.sv
// Single-port framebuffer arbiter: scan prefetch owns hpos%8==5 slots, clear > host write > readback elsewhere.
// Define FB_READBACK_EN to add the host cell readback path.
module fb_arbiter
  import fb_pkg::*;
(
  input  logic        pixel_clk,
  input  logic        rst_n,
  input  logic [11:0] hpos,
  input  logic [10:0] vpos,
  output pix_t        pix_out,
  output cell_addr_t  ram_addr,
  output logic        ram_we,
  output pix_t        ram_wdata,
  input  pix_t        ram_rdata,
  fb_arbiter_if.slave host
);
  logic [11:0] tgt_h_sum, tgt_h;
  logic [10:0] tgt_v;
  logic        wrap_h, scan_slot, free_slot, blank;
  logic        clr_req, wr_fire, wr_in_range, rd_fire;
  cell_addr_t  clr_addr, rd_addr;
  pix_t        clr_wdata;
  rd_tag_e     tag_q, tag_d;
  pix_t        next_cell_q, next_cell_d, cur_cell_q, cur_cell_d;

  // The prefetch targets the pixel three columns ahead, wrapping into the next line/frame.
  assign tgt_h_sum = hpos + 12'd3;
  assign wrap_h    = (tgt_h_sum >= H_TOTAL);
  assign tgt_h     = wrap_h ? (tgt_h_sum - H_TOTAL) : tgt_h_sum;
  assign tgt_v     = !wrap_h ? vpos : ((vpos == V_TOTAL - 11'd1) ? 11'd0 : vpos + 11'd1);

  assign scan_slot = (hpos[2:0] == 3'd5) && (tgt_h < H_ACTIVE) && (tgt_v < V_ACTIVE);
  assign free_slot = !scan_slot;
  assign blank     = (hpos >= H_ACTIVE) || (vpos >= V_ACTIVE);

  fb_clear_seq u_clear_seq (
    .clk     (pixel_clk),
    .rst_n   (rst_n),
    .start_i (host.clr_start),
    .data_i  (host.clr_data),
    .grant_i (rst_n && free_slot),
    .req_o   (clr_req),
    .addr_o  (clr_addr),
    .data_o  (clr_wdata)
  );

  assign host.clr_busy = clr_req;
  // A clear request arriving this cycle already outranks the host.
  assign host.wr_ready = rst_n && free_slot && !clr_req && !host.clr_start;
  assign wr_fire       = host.wr_valid && host.wr_ready;
  assign wr_in_range   = (host.wr_x < H_CELLS) && (host.wr_y < V_CELLS);

`ifdef FB_READBACK_EN
  logic rd_in_range, rd_oor_q;

  assign host.rd_ready = rst_n && free_slot && !clr_req && !host.clr_start && !host.wr_valid;
  assign rd_fire       = host.rd_valid && host.rd_ready;
  assign rd_in_range   = (host.rd_x < H_CELLS) && (host.rd_y < V_CELLS);
  assign rd_addr       = rd_in_range ? cell_addr(host.rd_x, host.rd_y) : '0;

  always_ff @(posedge pixel_clk) begin
    if (!rst_n) rd_oor_q <= 1'b0;
    else        rd_oor_q <= rd_fire && !rd_in_range;
  end

  assign host.rd_data_valid = (tag_q == TAG_RD);
  assign host.rd_data       = ((tag_q == TAG_RD) && !rd_oor_q) ? ram_rdata : '0;
`else
  assign rd_fire = 1'b0;
  assign rd_addr = '0;
`endif

  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    tag_d     = TAG_NONE;
    if (rst_n) begin
      if (scan_slot) begin
        ram_addr = cell_addr(tgt_h[10:3], tgt_v[9:3]);
        tag_d    = TAG_SCAN;
      end else if (clr_req) begin
        ram_addr  = clr_addr;
        ram_we    = 1'b1;
        ram_wdata = clr_wdata;
      end else if (wr_fire) begin
        if (wr_in_range) begin
          ram_addr  = cell_addr(host.wr_x, host.wr_y);
          ram_we    = 1'b1;
          ram_wdata = host.wr_data;
        end
      end else if (rd_fire) begin
        ram_addr = rd_addr;
        tag_d    = TAG_RD;
      end
    end
  end

  // Return data is steered by the tag of the cycle that issued the read.
  assign next_cell_d = (tag_q == TAG_SCAN) ? ram_rdata : next_cell_q;
  assign cur_cell_d  = (hpos[2:0] == 3'd7) ? next_cell_q : cur_cell_q;

  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      tag_q       <= TAG_NONE;
      next_cell_q <= '0;
      cur_cell_q  <= '0;
    end else begin
      tag_q       <= tag_d;
      next_cell_q <= next_cell_d;
      cur_cell_q  <= cur_cell_d;
    end
  end

  assign pix_out = (blank || !rst_n) ? '0 : cur_cell_q;
endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter with a behavioural 1-cycle-latency RAM and an expected-contents table.
module tb_fb_arbiter;
  import fb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] hpos;
  logic [10:0] vpos;
  pix_t        pix_out, ram_wdata, ram_rdata;
  cell_addr_t  ram_addr;
  logic        ram_we;

  fb_arbiter_if hif();

  fb_arbiter dut (
    .pixel_clk (clk),
    .rst_n     (rst_n),
    .hpos      (hpos),
    .vpos      (vpos),
    .pix_out   (pix_out),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .host      (hif)
  );

  always #5 clk = ~clk;

  pix_t mem     [0:16383];
  pix_t exp_mem [0:16383];
  int   n_chk = 0, n_fail = 0;
  int   we_cnt = 0, we325_cnt = 0, scan_viol = 0;
  logic last_busy = 1'b0;
  bit   tg_run = 1'b0;

  always @(posedge clk) begin
    ram_rdata <= mem[ram_addr];
    if (ram_we === 1'b1) begin
      mem[ram_addr] = ram_wdata;
      we_cnt <= we_cnt + 1;
      if (ram_addr == 14'd325) we325_cnt <= we325_cnt + 1;
      if (ram_addr == 14'd15999 && ram_wdata == 15'h7FFF) last_busy <= hif.clr_busy;
    end
  end

  function automatic bit is_scan(input int h, input int v);
    int th, tv;
    th = h + 3;
    tv = v;
    if (th >= 1680) begin
      th = th - 1680;
      tv = (v + 1) % 828;
    end
    return (h % 8 == 5) && (th < 1280) && (tv < 800);
  endfunction

  always @(negedge clk)
    if (rst_n === 1'b1 && hif.wr_ready === 1'b1 && is_scan(int'(hpos), int'(vpos)))
      scan_viol <= scan_viol + 1;

  function automatic pix_t exp_pix(input int h, input int v);
    if (h >= 1280 || v >= 800) return '0;
    return exp_mem[(v / 8) * 160 + (h / 8)];
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_chk++;
    if (obs !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, req);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
    if (tg_run) begin
      if (hpos == 12'd1679) begin
        hpos = 12'd0;
        vpos = (vpos == 11'd827) ? 11'd0 : vpos + 11'd1;
      end else begin
        hpos = hpos + 12'd1;
      end
    end
  endtask

  task automatic run_pix(input string tag, input int h0, input int v0, input int n);
    hpos   = 12'(h0);
    vpos   = 11'(v0);
    tg_run = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_eq(tag, pix_out, exp_pix(int'(hpos), int'(vpos)));
      nxt();
    end
    tg_run = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int   base, bad;
    bit   found;
    logic [7:0] oor_x [2];
    logic [6:0] oor_y [2];
    oor_x[0] = 8'd160; oor_y[0] = 7'd0;
    oor_x[1] = 8'd0;   oor_y[1] = 7'd100;

    for (int i = 0; i < 16384; i++) begin
      mem[i] = '0;
      exp_mem[i] = '0;
    end
    mem[0]   = 15'h7C00; exp_mem[0]   = 15'h7C00;
    mem[1]   = 15'h03E0; exp_mem[1]   = 15'h03E0;
    mem[2]   = 15'h0ABC; exp_mem[2]   = 15'h0ABC;
    mem[159] = 15'h5555; exp_mem[159] = 15'h5555;
    mem[160] = 15'h1234; exp_mem[160] = 15'h1234;
    mem[5000] = 15'h2AAA; exp_mem[5000] = 15'h2AAA;

    rst_n = 1'b0;
    hpos = 12'd13;
    vpos = 11'd0;
    hif.wr_valid = 1'b1; hif.wr_x = 8'd5; hif.wr_y = 7'd2; hif.wr_data = 15'h001F;
    hif.clr_start = 1'b0; hif.clr_data = '0;
`ifdef FB_READBACK_EN
    hif.rd_valid = 1'b0; hif.rd_x = '0; hif.rd_y = '0;
`endif
    repeat (3) nxt();
    @(negedge clk);
    check_eq("rst_pix_out", pix_out, 0);
    check_eq("rst_ram_we", ram_we, 0);
    check_eq("rst_ram_addr", ram_addr, 0);
    check_eq("rst_ram_wdata", ram_wdata, 0);
    check_eq("rst_wr_ready", hif.wr_ready, 0);
    check_eq("rst_clr_busy", hif.clr_busy, 0);
`ifdef FB_READBACK_EN
    check_eq("rst_rd_data_valid", hif.rd_data_valid, 0);
`endif
    hif.wr_valid = 1'b0;
    nxt();
    rst_n = 1'b1;
    nxt();

    // Line 0 from the frame-wrap prefetch to the end of line, then into vertical blank.
    run_pix("pix_line0", 1670, 827, 1690);
    run_pix("pix_vblank", 1670, 799, 20);
    run_pix("pix_line_wrap", 1670, 7, 18);

    // Host write held across a scan slot: stalls one cycle, then lands at 2*160+5.
    base = we325_cnt;
    hpos = 12'd5; vpos = 11'd20; tg_run = 1'b1;
    hif.wr_valid = 1'b1; hif.wr_x = 8'd5; hif.wr_y = 7'd2; hif.wr_data = 15'h001F;
    @(negedge clk);
    check_eq("wr_scan_stall_rdy", hif.wr_ready, 0);
    check_eq("wr_scan_stall_we", ram_we, 0);
    nxt();
    @(negedge clk);
    check_eq("wr_free_rdy", hif.wr_ready, 1);
    check_eq("wr_we", ram_we, 1);
    check_eq("wr_addr", ram_addr, 325);
    check_eq("wr_wdata", ram_wdata, 15'h001F);
    nxt();
    hif.wr_valid = 1'b0; tg_run = 1'b0;
    exp_mem[325] = 15'h001F;
    repeat (4) nxt();
    check_eq("wr_325_once", we325_cnt - base, 1);

    // Out-of-range writes complete the handshake without touching RAM.
    hpos = 12'd1300; vpos = 11'd20;
    for (int i = 0; i < 2; i++) begin
      hif.wr_valid = 1'b1; hif.wr_x = oor_x[i]; hif.wr_y = oor_y[i]; hif.wr_data = 15'h7777;
      @(negedge clk);
      check_eq("wr_oor_rdy", hif.wr_ready, 1);
      check_eq("wr_oor_we", ram_we, 0);
      nxt();
      hif.wr_valid = 1'b0;
      nxt();
    end

`ifdef FB_READBACK_EN
    hif.rd_valid = 1'b1; hif.rd_x = 8'd5; hif.rd_y = 7'd2;
    @(negedge clk);
    check_eq("rd_ready", hif.rd_ready, 1);
    nxt();
    hif.rd_valid = 1'b0;
    @(negedge clk);
    check_eq("rd_valid_pulse", hif.rd_data_valid, 1);
    check_eq("rd_data_5_2", hif.rd_data, 15'h001F);
    nxt();
    @(negedge clk);
    check_eq("rd_valid_drop", hif.rd_data_valid, 0);
    hif.rd_valid = 1'b1; hif.rd_x = 8'd200; hif.rd_y = 7'd0;
    nxt();
    hif.rd_valid = 1'b0;
    @(negedge clk);
    check_eq("rd_oor_valid", hif.rd_data_valid, 1);
    check_eq("rd_oor_data", hif.rd_data, 0);
    hif.rd_valid = 1'b1; hif.wr_valid = 1'b1; hif.wr_x = 8'd160; hif.wr_y = 7'd0;
    nxt();
    @(negedge clk);
    check_eq("rd_blocked_by_wr", hif.rd_ready, 0);
    nxt();
    hif.rd_valid = 1'b0; hif.wr_valid = 1'b0;
    nxt();
`endif

    // Clear aborted by reset after cell 4000 is written.
    hpos = 12'd1300; vpos = 11'd810;
    hif.clr_start = 1'b1; hif.clr_data = 15'h1111;
    nxt();
    hif.clr_start = 1'b0;
    @(negedge clk);
    check_eq("clr_busy_set", hif.clr_busy, 1);
    found = 1'b0;
    for (int i = 0; i < 6000 && !found; i++) begin
      @(negedge clk);
      if (ram_we === 1'b1 && ram_addr == 14'd4000) found = 1'b1;
      else nxt();
    end
    check_eq("clr_reach_4000", found, 1);
    nxt();
    rst_n = 1'b0;
    base = we_cnt;
    nxt();
    @(negedge clk);
    check_eq("abort_busy_low", hif.clr_busy, 0);
    repeat (4) nxt();
    rst_n = 1'b1;
    repeat (20) nxt();
    check_eq("abort_no_writes", we_cnt - base, 0);
    check_eq("abort_cell_4000", mem[4000], 15'h1111);
    check_eq("abort_cell_4001", mem[4001], 0);
    check_eq("abort_cell_5000", mem[5000], 15'h2AAA);

    // Full clear racing a held host write, with the timing generator running.
    hpos = 12'd0; vpos = 11'd0; tg_run = 1'b1;
    hif.clr_start = 1'b1; hif.clr_data = 15'h7FFF;
    hif.wr_valid = 1'b1; hif.wr_x = 8'd5; hif.wr_y = 7'd2; hif.wr_data = 15'h0001;
    base = we_cnt;
    @(negedge clk);
    check_eq("clr_wins_rdy", hif.wr_ready, 0);
    nxt();
    hif.clr_start = 1'b0;
    bad = 0;
    found = 1'b0;
    for (int i = 0; i < 20000 && !found; i++) begin
      @(negedge clk);
      if (!hif.clr_busy) found = 1'b1;
      else begin
        if (hif.wr_ready) bad++;
        nxt();
      end
    end
    check_eq("clr_done", found, 1);
    check_eq("clr_write_count", we_cnt - base, 16000);
    check_eq("clr_wr_ready_low", bad, 0);
    check_eq("clr_busy_at_last", last_busy, 1);
    found = 1'b0;
    for (int i = 0; i < 16 && !found; i++) begin
      @(negedge clk);
      if (hif.wr_ready === 1'b1) found = 1'b1;
      else nxt();
    end
    check_eq("wr_after_clr_rdy", found, 1);
    check_eq("wr_after_clr_addr", ram_addr, 325);
    nxt();
    hif.wr_valid = 1'b0; tg_run = 1'b0;
    nxt();
    for (int i = 0; i < 16000; i++) exp_mem[i] = 15'h7FFF;
    exp_mem[325] = 15'h0001;
    bad = 0;
    for (int i = 0; i < 16000; i++) if (mem[i] !== exp_mem[i]) bad++;
    check_eq("fb_contents", bad, 0);

    run_pix("pix_after_clr", 1670, 827, 40);
    run_pix("pix_row2", 1670, 15, 66);
    check_eq("wr_rdy_in_scan_slot", scan_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
